servo_motion_sequencer: RTL and testbench



---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_motion_sequencer_stepper.sv | 33 +++
 rtl/servo_motion_sequencer.sv | 117 +++++++++++
 tb/tb_servo_motion_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion sequencer
// and the PWM generator it feeds.
package servo_pkg;

  typedef logic [7:0] angle_t;
  typedef logic [1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    PULSE
  } seq_state_t;

  localparam int MAX_DEG_C      = 180;
  localparam int FRAME_CYCLES_C = 1000000;

  // Generator pulse widths at 50 MHz: 1.0 ms .. 2.0 ms
  localparam int PWM_MIN_CYCLES_C = 50000;
  localparam int PWM_MAX_CYCLES_C = 100000;

endpackage

// File: rtl/servo_motion_sequencer_stepper.sv
// One rate-limited step of a channel's current angle toward its target.
// Pure combinational; never overshoots the target.
module angle_stepper
  import servo_pkg::*;
#(
  parameter int STEP_DEG = 2
) (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] nxt
);

  logic [8:0] c9;
  logic [8:0] t9;
  logic [8:0] s9;
  logic [8:0] d9;

  always_comb begin
    c9  = {1'b0, cur};
    t9  = {1'b0, tgt};
    s9  = 9'(STEP_DEG);
    d9  = '0;
    nxt = cur;
    if (t9 > c9) begin
      d9  = t9 - c9;
      nxt = angle_t'(c9 + ((d9 < s9) ? d9 : s9));
    end else if (c9 > t9) begin
      d9  = c9 - t9;
      nxt = angle_t'(c9 - ((d9 < s9) ? d9 : s9));
    end
  end

endmodule

// File: rtl/servo_motion_sequencer.sv
// Frame-paced, rate-limited angle sequencer in front of the
// four-channel servo PWM generator.
module servo_motion_sequencer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_C,
  parameter int STEP_DEG     = 2,
  parameter int MAX_DEG      = MAX_DEG_C,
  parameter int HOME_DEG     = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic [7:0] cmd_angle,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       nextangle,
  output logic       frame_tick,
  output logic       moving,
  output logic       settled
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
  localparam angle_t MAX_A  = angle_t'(MAX_DEG);
  localparam angle_t HOME_A = angle_t'(HOME_DEG);

  logic [CW-1:0] cnt;
  seq_state_t    state;
  seq_state_t    state_d;
  chan_t         idx;
  angle_t        cur [4];
  angle_t        tgt [4];
  angle_t        tgt_w [4];
  angle_t        cmd_clamped;
  angle_t        step_nxt;
  logic          init_load;
  logic          fire;
  logic          pending;

  assign frame_tick  = (cnt == LAST);
  assign cmd_ready   = (state == IDLE) && !rst;
  assign fire        = cmd_valid && cmd_ready;
  assign cmd_clamped = (cmd_angle > MAX_A) ? MAX_A : cmd_angle;
  assign settled     = !moving && !init_load && (state == IDLE);

  // Targets as they will be after this cycle's write, so a write
  // landing on the frame tick still starts that frame's update.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tgt_w[i] = (fire && cmd_chan == chan_t'(i)) ? cmd_clamped : tgt[i];
      pending  = pending | (cur[i] != tgt_w[i]);
    end
  end

  angle_stepper #(
    .STEP_DEG(STEP_DEG)
  ) u_step (
    .cur(cur[idx]),
    .tgt(tgt[idx]),
    .nxt(step_nxt)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (frame_tick && (pending || init_load)) state_d = UPDATE;
      UPDATE:  if (idx == 2'd3) state_d = PULSE;
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      state     <= IDLE;
      idx       <= '0;
      init_load <= 1'b1;
      nextangle <= 1'b0;
      moving    <= 1'b0;
      angle1    <= HOME_A;
      angle2    <= HOME_A;
      angle3    <= HOME_A;
      angle4    <= HOME_A;
      for (int i = 0; i < 4; i++) begin
        cur[i] <= HOME_A;
        tgt[i] <= HOME_A;
      end
    end else begin
      cnt       <= frame_tick ? '0 : cnt + 1'b1;
      state     <= state_d;
      moving    <= pending;
      nextangle <= (state == PULSE);
      if (fire) tgt[cmd_chan] <= cmd_clamped;
      if (state == UPDATE) begin
        cur[idx] <= step_nxt;
        idx      <= idx + 1'b1;
        // Last channel's step goes straight to the output bus so
        // all four angles settle a full clock before the strobe.
        if (idx == 2'd3) begin
          angle1 <= cur[0];
          angle2 <= cur[1];
          angle3 <= cur[2];
          angle4 <= step_nxt;
        end
      end
      if (state == PULSE) init_load <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Randomised bench for servo_motion_sequencer against a
// frame-level behavioural model.
module tb_servo_motion_sequencer;

  localparam int FC   = 100;
  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_chan = '0;
  logic [7:0] cmd_angle = '0;
  logic       cmd_ready;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       nextangle, frame_tick, moving, settled;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  servo_motion_sequencer #(
    .FRAME_CYCLES(FC),
    .STEP_DEG(STEP),
    .MAX_DEG(180),
    .HOME_DEG(90)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan),
    .cmd_angle(cmd_angle),
    .angle1(angle1),
    .angle2(angle2),
    .angle3(angle3),
    .angle4(angle4),
    .nextangle(nextangle),
    .frame_tick(frame_tick),
    .moving(moving),
    .settled(settled)
  );

  // Model: counter, phase since a triggering tick (0 = idle, 1..5 busy)
  int m_cnt = 0;
  int m_ph = 0;
  int m_rel = 0;
  bit m_init = 1'b1;
  bit m_na = 1'b0;
  int m_cur [4];
  int m_tgt [4];
  int m_out [4];
  int m_new [4];
  int na_cnt = 0;
  int first_na = -1;
  int max_a2 = 0;
  int max_a3 = 0;

  function automatic int step1(int c, int t);
    if (t > c) return c + (((t - c) < STEP) ? (t - c) : STEP);
    if (c > t) return c - (((c - t) < STEP) ? (c - t) : STEP);
    return c;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : compare
    bit r, v, any;
    int c, a;
    r = rst;
    v = cmd_valid;
    c = int'(cmd_chan);
    a = int'(cmd_angle);
    if (r) begin
      m_cnt = 0; m_ph = 0; m_init = 1'b1; m_na = 1'b0; m_rel = 0;
      first_na = -1;
      for (int i = 0; i < 4; i++) begin
        m_cur[i] = 90; m_tgt[i] = 90; m_out[i] = 90;
      end
    end else begin
      m_rel++;
      m_na = (m_ph == 5);
      if (v && m_ph == 0) m_tgt[c] = (a > 180) ? 180 : a;
      any = 1'b0;
      for (int i = 0; i < 4; i++) any |= (m_cur[i] != m_tgt[i]);
      if (m_ph == 0 && m_cnt == FC - 1 && (any || m_init)) begin
        for (int i = 0; i < 4; i++) m_new[i] = step1(m_cur[i], m_tgt[i]);
        for (int i = 0; i < 4; i++) m_cur[i] = m_new[i];
        m_ph = 1;
      end else if (m_ph == 5) begin
        m_ph = 0;
        m_init = 1'b0;
      end else if (m_ph > 0) begin
        m_ph++;
        if (m_ph == 5) for (int i = 0; i < 4; i++) m_out[i] = m_new[i];
      end
      m_cnt = (m_cnt == FC - 1) ? 0 : m_cnt + 1;
    end
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= (m_cur[i] != m_tgt[i]);
    #1;
    chk("angle1", int'(angle1), m_out[0]);
    chk("angle2", int'(angle2), m_out[1]);
    chk("angle3", int'(angle3), m_out[2]);
    chk("angle4", int'(angle4), m_out[3]);
    chk("nextangle", int'(nextangle), int'(m_na));
    chk("frame_tick", int'(frame_tick), int'(m_cnt == FC - 1));
    chk("cmd_ready", int'(cmd_ready), int'(!r && m_ph == 0));
    chk("settled", int'(settled), int'(m_ph == 0 && !m_init && !any));
    if (m_ph == 0) chk("moving", int'(moving), int'(any));
    if (nextangle) begin
      na_cnt++;
      if (first_na < 0) first_na = m_rel + 1;
    end
    if (int'(angle2) > max_a2) max_a2 = int'(angle2);
    if (int'(angle3) > max_a3) max_a3 = int'(angle3);
  end

  task automatic wr(int ch, int ang);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_chan  = 2'(ch);
    cmd_angle = 8'(ang);
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("wr_timeout", k, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic frames(int n);
    repeat (n * FC) @(negedge clk);
  endtask

  initial begin
    int base, k, lo;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-up load of the home pose, then a quiet static pose
    base = na_cnt;
    repeat (11 * FC + 10) @(negedge clk);
    chk("t1_first_na", first_na, 106);
    chk("t1_pulses", na_cnt - base, 1);
    chk("t1_settled", int'(settled), 1);

    // Small ramp on ch0
    base = na_cnt;
    wr(0, 100);
    frames(6);
    chk("t2_pulses", na_cnt - base, 5);
    chk("t2_angle1", int'(angle1), 100);
    chk("t2_moving", int'(moving), 0);
    base = na_cnt;
    frames(3);
    chk("t2_quiet", na_cnt - base, 0);

    // Clamped target on ch2
    base = na_cnt;
    max_a3 = 0;
    wr(2, 250);
    frames(47);
    chk("t3_pulses", na_cnt - base, 45);
    chk("t3_angle3", int'(angle3), 180);
    chk("t3_max", max_a3, 180);

    // Odd target on ch1, then down to zero
    base = na_cnt;
    wr(1, 91);
    frames(2);
    chk("t4_angle2", int'(angle2), 91);
    chk("t4_pulses", na_cnt - base, 1);
    base = na_cnt;
    max_a2 = 0;
    wr(1, 0);
    frames(47);
    chk("t4_zero", int'(angle2), 0);
    chk("t4_pulses2", na_cnt - base, 46);
    chk("t4_max", max_a2, 91);

    // Write on the tick, then a held write across the busy window
    wr(3, 120);
    k = 0;
    while (m_cnt != FC - 1 && k < 3 * FC) begin
      @(negedge clk);
      k++;
    end
    chk("t5_find_tick", int'(m_cnt == FC - 1), 1);
    cmd_valid = 1'b1;
    cmd_chan  = 2'd0;
    cmd_angle = 8'd60;
    @(negedge clk);
    cmd_chan  = 2'd1;
    cmd_angle = 8'd30;
    lo = 0;
    while (!cmd_ready && lo < 20) begin
      @(negedge clk);
      lo++;
    end
    chk("t5_ready_low", lo, 5);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_coincident", int'(angle1), 98);
    frames(2);

    // Reset in the middle of an update sequence
    wr(0, 150);
    k = 0;
    while (m_ph != 2 && k < 3 * FC) begin
      @(negedge clk);
      k++;
    end
    chk("t6_in_update", m_ph, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = na_cnt;
    repeat (FC + 10) @(negedge clk);
    chk("t6_pulses", na_cnt - base, 1);
    chk("t6_first_na", first_na, 106);
    chk("t6_angle1", int'(angle1), 90);

    // Random traffic with occasional resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
      wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    frames(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
